// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Groups the fetch requester, data requester and main_mem signals of the
// single-port memory arbiter.
//   slave  : arbiter side (requests and memory read data in; responses,
//            memory address/data/write/select and conflict count out)
//   master : environment side (requesters plus memory model)
interface mem_port_arbiter_if #(
    parameter int N     = 32,
    parameter int CNT_W = 16
);
    // fetch requester
    logic             if_req;
    logic [N-1:0]     if_adr;
    logic [N-1:0]     if_rdata;
    logic             if_ack;
    // data requester
    logic             d_req;
    logic             d_we;
    logic [N-1:0]     d_adr;
    logic [N-1:0]     d_wdata;
    logic [N-1:0]     d_rdata;
    logic             d_ack;
    logic             d_err;
    // main_mem
    logic [N-1:0]     mem_adr;
    logic [N-1:0]     mem_wdata;
    logic [N-1:0]     mem_rdata;
    logic             mem_write;
    logic             for_data_mem;
    // statistics
    logic [CNT_W-1:0] conflict_cnt;

    modport slave (
        input  if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack, d_err,
               mem_adr, mem_wdata, mem_write, for_data_mem, conflict_cnt
    );

    modport master (
        output if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack, d_err,
               mem_adr, mem_wdata, mem_write, for_data_mem, conflict_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the unified instruction/data main_mem between the fetch and data
// requesters of the multi-cycle core. Round-robin arbitration, fixed
// IDLE -> ACCESS -> (WPULSE) -> RESP sequence, registered outputs only.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : mem_port_arbiter_if.slave (requests, responses, memory side)
module mem_port_arbiter #(
    parameter int N         = 32,
    parameter int MEM_WORDS = 89,
    parameter int DATA_BASE = 51,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_port_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, WPULSE, RESP} state_e;

    state_e           state_q, state_d;
    logic             gnt_data_q, gnt_data_d;   // current grant is the data port
    logic             last_data_q, last_data_d; // previous grant was the data port
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic [N-1:0]     mem_adr_q, mem_adr_d;
    logic [N-1:0]     mem_wdata_q, mem_wdata_d;
    logic             fdm_q, fdm_d;
    logic [N-1:0]     if_rdata_q, if_rdata_d;
    logic [N-1:0]     d_rdata_q, d_rdata_d;
    logic             if_ack_q, if_ack_d;
    logic             d_ack_q, d_ack_d;
    logic             d_err_q, d_err_d;
    logic             mem_write_q, mem_write_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic both_req;
    logic pick_data;
    logic d_bad;

    assign both_req  = bus.if_req & bus.d_req;
    // On a tie the port that did not win last time goes first.
    assign pick_data = bus.d_req & (~bus.if_req | ~last_data_q);
    assign d_bad     = (bus.d_adr >= N'(MEM_WORDS)) |
                       (bus.d_we & (bus.d_adr < N'(DATA_BASE)));

    always_comb begin
        state_d     = state_q;
        gnt_data_d  = gnt_data_q;
        last_data_d = last_data_q;
        we_d        = we_q;
        err_d       = err_q;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        fdm_d       = fdm_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        mem_write_d = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (both_req && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
                if (bus.if_req || bus.d_req) begin
                    state_d    = ACCESS;
                    gnt_data_d = pick_data;
                    fdm_d      = pick_data;
                    we_d       = pick_data & bus.d_we;
                    err_d      = pick_data & d_bad;
                    mem_adr_d  = pick_data ? bus.d_adr : bus.if_adr;
                    // fetches never write, so the write bus keeps its last data
                    if (pick_data) mem_wdata_d = bus.d_wdata;
                end
            end
            ACCESS: begin
                if (we_q && !err_q) begin
                    // address/data have been stable for one cycle already
                    state_d     = WPULSE;
                    mem_write_d = 1'b1;
                end else begin
                    state_d  = RESP;
                    if_ack_d = ~gnt_data_q;
                    d_ack_d  = gnt_data_q;
                    d_err_d  = gnt_data_q & err_q;
                    // only clean reads update read data; blocked accesses leave it
                    if (!err_q) begin
                        if (gnt_data_q) d_rdata_d  = bus.mem_rdata;
                        else            if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            WPULSE: begin
                state_d  = RESP;
                if_ack_d = ~gnt_data_q;
                d_ack_d  = gnt_data_q;
            end
            RESP: begin
                state_d     = IDLE;
                last_data_d = gnt_data_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gnt_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            fdm_q       <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            mem_write_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_data_q  <= gnt_data_d;
            last_data_q <= last_data_d;
            we_q        <= we_d;
            err_q       <= err_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            fdm_q       <= fdm_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            mem_write_q <= mem_write_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.if_rdata     = if_rdata_q;
    assign bus.if_ack       = if_ack_q;
    assign bus.d_rdata      = d_rdata_q;
    assign bus.d_ack        = d_ack_q;
    assign bus.d_err        = d_err_q;
    assign bus.mem_adr      = mem_adr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_write    = mem_write_q;
    assign bus.for_data_mem = fdm_q;
    assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int N  = 32;
    localparam int MW = 89;
    localparam int DB = 51;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.N(N), .CNT_W(CW)) bus();

    mem_port_arbiter #(.N(N), .MEM_WORDS(MW), .DATA_BASE(DB), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- main_mem environment: mem[i] = i + 4 ----------------
    logic [N-1:0] mem [MW];
    logic [N-1:0] env_idx;
    assign env_idx       = bus.for_data_mem ? bus.mem_adr : (bus.mem_adr >> 2);
    assign bus.mem_rdata = (env_idx < N'(MW)) ? mem[env_idx[6:0]] : '0;

    initial begin
        for (int i = 0; i < MW; i++) mem[i] = N'(i + 4);
        forever begin
            @(posedge bus.mem_write);
            if (env_idx < N'(MW)) mem[env_idx[6:0]] = bus.mem_wdata;
        end
    end

    // ---------------- transaction-level model ----------------
    // Tracks at which clock edge each transaction is granted / pulses / acks.
    logic [N-1:0]  mm [MW];
    int            ec, next_e, ack_e, pulse_e;
    bit            last_d, p_gd, p_err, p_we;
    logic [N-1:0]  p_val;
    logic [CW-1:0] m_cnt;
    bit            exp_if_ack, exp_d_ack, exp_d_err, exp_mw, exp_fdm;
    logic [N-1:0]  exp_adr, exp_wdata, exp_if_rdata, exp_d_rdata;

    task automatic model_rst();
        ec = 0; next_e = 0; ack_e = -1; pulse_e = -1; last_d = 0;
        p_gd = 0; p_err = 0; p_we = 0; p_val = '0; m_cnt = '0;
        exp_if_ack = 0; exp_d_ack = 0; exp_d_err = 0; exp_mw = 0; exp_fdm = 0;
        exp_adr = '0; exp_wdata = '0; exp_if_rdata = '0; exp_d_rdata = '0;
    endtask

    initial begin
        for (int i = 0; i < MW; i++) mm[i] = N'(i + 4);
        model_rst();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_rst();
            end else begin
                if (ec >= next_e && (bus.if_req || bus.d_req)) begin
                    bit            gd, bad;
                    logic [N-1:0]  a, idx;
                    if (bus.if_req && bus.d_req && m_cnt != '1) m_cnt = m_cnt + 1'b1;
                    gd  = bus.d_req && !(bus.if_req && last_d);
                    a   = bus.d_adr;
                    bad = gd && (a >= MW || (bus.d_we && a < DB));
                    p_gd = gd; p_err = bad; p_we = gd && bus.d_we;
                    exp_adr = gd ? a : bus.if_adr;
                    exp_fdm = gd;
                    if (gd) exp_wdata = bus.d_wdata;
                    idx   = gd ? a : (bus.if_adr >> 2);
                    p_val = (idx < MW) ? mm[idx[6:0]] : '0;
                    if (p_we && !bad) begin
                        mm[a[6:0]] = bus.d_wdata;
                        pulse_e = ec + 1;
                        ack_e   = ec + 2;
                    end else begin
                        pulse_e = -1;
                        ack_e   = ec + 1;
                    end
                    next_e = ack_e + 2;
                end
                exp_if_ack = (ec == ack_e) && !p_gd;
                exp_d_ack  = (ec == ack_e) && p_gd;
                exp_d_err  = exp_d_ack && p_err;
                exp_mw     = (ec == pulse_e);
                if (ec == ack_e) begin
                    if (!p_gd) exp_if_rdata = p_val;
                    else if (!p_err && !p_we) exp_d_rdata = p_val;
                    last_d = p_gd;
                end
                ec++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("if_ack", bus.if_ack, exp_if_ack);
            check("d_ack", bus.d_ack, exp_d_ack);
            if (exp_d_ack) check("d_err", bus.d_err, exp_d_err);
            check("mem_write", bus.mem_write, exp_mw);
            check("mem_adr", bus.mem_adr, exp_adr);
            check("for_data_mem", bus.for_data_mem, exp_fdm);
            check("mem_wdata", bus.mem_wdata, exp_wdata);
            check("if_rdata", bus.if_rdata, exp_if_rdata);
            check("d_rdata", bus.d_rdata, exp_d_rdata);
            check("conflict_cnt", bus.conflict_cnt, m_cnt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic data_op(input bit we, input logic [N-1:0] adr, input logic [N-1:0] wd,
                           output logic [N-1:0] rd, output bit err, output int lat,
                           output int plat, output int npulse);
        @(posedge clk); #1;
        bus.d_req = 1; bus.d_we = we; bus.d_adr = adr; bus.d_wdata = wd;
        lat = 0; plat = -1; npulse = 0; rd = '0; err = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) check("acc_adr", bus.mem_adr, adr);
            if (bus.mem_write) begin
                npulse++;
                if (plat < 0) plat = k;
                check("pulse_adr", bus.mem_adr, adr);
                check("pulse_wdata", bus.mem_wdata, wd);
            end
            if (bus.d_ack) begin
                lat = k; rd = bus.d_rdata; err = bus.d_err;
                break;
            end
        end
        bus.d_req = 0;
        if (lat == 0) begin
            n_tests++; n_fail++;
            $display("FAIL d_ack_timeout: got none expected ack for adr %0d", adr);
        end
    endtask

    task automatic fetch_op(input logic [N-1:0] adr, output logic [N-1:0] rd, output int lat);
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_adr = adr;
        lat = 0; rd = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                check("f_acc_adr", bus.mem_adr, adr);
                check("f_acc_fdm", bus.for_data_mem, 1'b0);
            end
            if (bus.if_ack) begin lat = k; rd = bus.if_rdata; break; end
        end
        bus.if_req = 0;
        if (lat == 0) begin
            n_tests++; n_fail++;
            $display("FAIL if_ack_timeout: got none expected ack for adr %0d", adr);
        end
    endtask

    initial begin
        logic [N-1:0] rd;
        bit           err;
        int           lat, plat, np;
        bit           ord [4];
        int           tms [4];
        int           nack, seen;

        bus.if_req = 0; bus.if_adr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_adr = '0; bus.d_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_if_ack", bus.if_ack, 0);
        check("rst_d_ack", bus.d_ack, 0);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_mem_adr", bus.mem_adr, 0);
        check("rst_cnt", bus.conflict_cnt, 0);
        rst = 1;

        fetch_op(32'd8, rd, lat);
        check("fetch_lat", lat, 2);
        check("fetch_data", rd, 32'd6);

        data_op(0, 32'd63, '0, rd, err, lat, plat, np);
        check("rd63_lat", lat, 2);  check("rd63_data", rd, 32'd67);
        check("rd63_err", err, 0);  check("rd63_pulses", np, 0);

        data_op(1, 32'd70, 32'h1234, rd, err, lat, plat, np);
        check("wr70_lat", lat, 3);  check("wr70_pulse_at", plat, 2);
        check("wr70_pulses", np, 1); check("wr70_err", err, 0);
        check("wr70_drdata_held", rd, 32'd67);

        data_op(0, 32'd70, '0, rd, err, lat, plat, np);
        check("rd70_data", rd, 32'h1234);

        data_op(1, 32'd5, 32'hdead, rd, err, lat, plat, np);
        check("wr5_lat", lat, 2);   check("wr5_err", err, 1);
        check("wr5_pulses", np, 0);
        data_op(0, 32'd5, '0, rd, err, lat, plat, np);
        check("rd5_data", rd, 32'd9); check("rd5_err", err, 0);

        data_op(0, 32'd200, '0, rd, err, lat, plat, np);
        check("rd200_err", err, 1); check("rd200_lat", lat, 2);
        check("rd200_held", rd, 32'd9);

        // region boundaries
        data_op(1, 32'd51, 32'h55, rd, err, lat, plat, np);
        check("wr51_err", err, 0);  check("wr51_pulses", np, 1);
        data_op(1, 32'd50, 32'h66, rd, err, lat, plat, np);
        check("wr50_err", err, 1);  check("wr50_pulses", np, 0);
        data_op(0, 32'd88, '0, rd, err, lat, plat, np);
        check("rd88_data", rd, 32'd92); check("rd88_err", err, 0);
        data_op(0, 32'd89, '0, rd, err, lat, plat, np);
        check("rd89_err", err, 1);

        // contention: both held high from reset
        @(posedge clk); #1;
        rst = 0;
        bus.if_req = 1; bus.if_adr = 32'd12;
        bus.d_req = 1;  bus.d_we = 0; bus.d_adr = 32'd60;
        @(posedge clk); #1;
        rst = 1;
        nack = 0;
        for (int k = 1; k <= 40 && nack < 4; k++) begin
            @(posedge clk); #1;
            if (bus.if_ack) begin ord[nack] = 0; tms[nack] = k; nack++; end
            else if (bus.d_ack) begin ord[nack] = 1; tms[nack] = k; nack++; end
        end
        bus.if_req = 0; bus.d_req = 0;
        check("cont_acks", nack, 4);
        if (nack == 4) begin
            check("cont_g0", ord[0], 1); check("cont_g1", ord[1], 0);
            check("cont_g2", ord[2], 1); check("cont_g3", ord[3], 0);
            check("cont_t0", tms[0], 2);
            check("cont_gap1", tms[1] - tms[0], 3);
            check("cont_gap2", tms[2] - tms[1], 3);
            check("cont_gap3", tms[3] - tms[2], 3);
        end
        check("cont_cnt", bus.conflict_cnt, 4);
        check("cont_ifdata", bus.if_rdata, 32'd7);
        check("cont_ddata", bus.d_rdata, 32'd64);
        repeat (2) @(posedge clk);

        // reset during WPULSE
        #1;
        bus.d_req = 1; bus.d_we = 1; bus.d_adr = 32'd75; bus.d_wdata = 32'hbeef;
        seen = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (bus.mem_write) begin seen = 1; break; end
        end
        check("mid_pulse_seen", seen, 1);
        rst = 0; bus.d_req = 0;
        #1;
        check("mid_mw_async", bus.mem_write, 0);
        check("mid_ack", bus.d_ack, 0);
        @(posedge clk); #1;
        rst = 1;
        #1;
        check("post_mem_adr", bus.mem_adr, 0);
        check("post_wdata", bus.mem_wdata, 0);
        check("post_fdm", bus.for_data_mem, 0);
        check("post_if_rdata", bus.if_rdata, 0);
        check("post_d_rdata", bus.d_rdata, 0);
        check("post_cnt", bus.conflict_cnt, 0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus.d_ack || bus.if_ack || bus.mem_write) seen++;
        end
        check("post_no_activity", seen, 0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port controller that shares the unified instruction/data `main_mem` between the instruction-fetch requester and the data-access requester of the multi-cycle RISC-V core. It arbitrates round-robin, sequences each access through a fixed state machine, and drives the memory address, data, `for_data_mem` select and a glitch-free `mem_write` pulse. Read data is registered and returned with a one-cycle acknowledge. Data writes into the instruction region, and accesses beyond the array, are blocked and flagged.

## Interface
- `N`, 32: address/data width.
- `MEM_WORDS`, 89: memory depth in words; valid word index 0..MEM_WORDS-1.
- `DATA_BASE`, 51: first data word index; indices below this are the instruction region.
- `CNT_W`, 16: width of the conflict counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request, held until `if_ack`.
- `if_adr`  in  N  fetch byte address (PC).
- `if_rdata`  out  N  fetched instruction.
- `if_ack`  out  1  one-cycle fetch completion.
- `d_req`  in  1  data request, held until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_adr`  in  N  data word index.
- `d_wdata`  in  N  write data.
- `d_rdata`  out  N  read data.
- `d_ack`  out  1  one-cycle data completion.
- `d_err`  out  1  valid with `d_ack`; access was blocked.
- `mem_adr`  out  N  to memory `adr`.
- `mem_wdata`  out  N  to memory `data_in`.
- `mem_rdata`  in  N  from memory `data_out`, combinational.
- `mem_write`  out  1  to memory `mem_write`, edge-sensitive at the memory.
- `for_data_mem`  out  1  0 = fetch (memory uses adr>>2), 1 = data (word index).
- `conflict_cnt`  out  CNT_W  saturating count of contended arbitration cycles.

## Operation
- States: IDLE, ACCESS, WPULSE, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester not granted last. `last_grant` resets to "fetch", so data wins the first tie.
  - On grant, register `mem_adr`, `mem_wdata` and `for_data_mem`, then go to ACCESS.
  - Fetch grant: `mem_adr = if_adr`, `for_data_mem = 0`.
  - Data grant: `mem_adr = d_adr`, `for_data_mem = 1`.
- **Data error check** (evaluated at grant): error if `d_adr >= MEM_WORDS`, or if `d_we = 1` and `d_adr < DATA_BASE`.
  - On error: `mem_write` never asserts and `d_rdata` is not updated.
  - Fetch is never checked.
- **ACCESS**
  - Read: capture `mem_rdata` into `if_rdata` or `d_rdata` at exit, then go to RESP.
  - Write, no error: go to WPULSE.
  - Write with error: go to RESP.
- **WPULSE**: `mem_write = 1` for this whole cycle, with address and data already stable for one cycle; then go to RESP.
- **RESP**
  - Assert the granted ack for exactly one cycle; `d_err` is valid with `d_ack`.
  - Update `last_grant`, then go to IDLE.
- **Conflict counter**: `conflict_cnt` increments on each IDLE cycle with `if_req & d_req`, saturating at all-ones.
- **Data path rules**
  - `mem_adr` and `mem_wdata` hold their last values outside ACCESS/WPULSE.
  - `if_rdata` and `d_rdata` hold until their next capture.
- **Requester contract**: deassert `req` at the clock edge that ends the ack cycle. A `req` still high in the following IDLE is treated as a new request.
- **Reset**: asynchronous reset mid-access returns the FSM to IDLE immediately and forces `mem_write` to 0. The aborted access is never acknowledged.

## Timing
- Reset values:
  - All outputs 0, FSM in IDLE.
  - `last_grant` = fetch.
- All outputs are registered; no combinational path from inputs to outputs.
- Read latency: request seen in IDLE at cycle T; ACCESS at T+1; ack at T+2. Three cycles per read.
- Write latency: IDLE at T, ACCESS at T+1, WPULSE at T+2, ack at T+3. Four cycles per write.
- Blocked write: acked at T+2 with `d_err = 1`.
- `mem_write` rises one cycle after `mem_adr`/`mem_wdata` settle and falls before they change. There is no glitch, so the memory's posedge write sees stable inputs.
- A pending loser is granted in the IDLE cycle immediately after the winner's RESP.
- Inputs are sampled only in IDLE; changes to held inputs after grant are ignored.

## Test plan
- **Reset then single fetch**: `if_adr = 8`, `if_req = 1`.
  - Expect `mem_adr = 8` and `for_data_mem = 0` in ACCESS.
  - `if_ack` high 2 cycles after request; `if_rdata = mem[2]`.
- **Data read**: `d_adr = 63`, `d_we = 0`.
  - `d_ack` at T+2, `d_rdata = 67`, `d_err = 0`, `mem_write` stays 0.
- **Data write**: `d_adr = 70`, `d_wdata = 0x1234`.
  - `mem_write` high only in cycle T+2, with `mem_adr = 70` stable from T+1.
  - `d_ack` at T+3; a following read of 70 returns 0x1234.
- **Blocked accesses**:
  - Write to `d_adr = 5`: `mem_write` never high, `d_ack` with `d_err = 1` at T+2, `mem[5]` unchanged.
  - Read of `d_adr = 200`: `d_err = 1`.
- **Contention**: `if_req` and `d_req` both held high from reset.
  - Grant order is data, fetch, data, fetch.
  - `conflict_cnt` increments once per contended IDLE; each ack lands 3 cycles apart for reads.
- **Reset mid-write**: assert `rst = 0` during WPULSE.
  - `mem_write` drops asynchronously and no ack is issued.
  - After release, FSM is in IDLE with all outputs 0.
